// File: rtl/pattern_pkg.sv
// Shared types and constants for the sync-pattern framer and its detectors.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pattern_pkg;

    // Framer FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        DATA = 2'd2,
        GAP  = 2'd3
    } state_t;

    // Line symbols shared with the detectors
    localparam logic SYM_B = 1'b0;
    localparam logic SYM_C = 1'b1;

    // Default sync pattern, sent MSB first
    localparam int         SYNC_W_DEF   = 5;
    localparam logic [4:0] SYNC_PAT_DEF = {SYM_B, SYM_C, SYM_C, SYM_B, SYM_C};

    // Payload history that forces a stuffed B (prefix of the sync pattern)
    localparam logic [3:0] STUFF_HIST = {SYM_B, SYM_C, SYM_C, SYM_B};

    // Width of the per-phase slot index
    localparam int IDX_W = 16;

endpackage

// File: rtl/pattern_stuffer.sv
// Payload bit-stuffing decision: tracks the last 4 emitted payload bits.
// Latency: stuff is combinational from history; history updates 1 clk after a slot.
// Backpressure: none; advances only on slots the framer actually emits.
module pattern_stuffer
    import pattern_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic advance,
    input  logic emit_bit,
    output logic stuff
);

    logic [3:0] hist;

    // A B is forced whenever the history could complete the sync pattern
    assign stuff = (hist == STUFF_HIST);

    // History of emitted payload bits, stuffed bits included
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist <= '0;
        end else if (clear) begin
            hist <= '0;
        end else if (advance) begin
            hist <= {hist[2:0], emit_bit};
        end
    end

endmodule

// File: rtl/pattern_framer.sv
// Serial framer: sync pattern then payload MSB-first, one bit per bit_en_i strobe.
// Latency: first sync bit on the first strobe edge after the accept edge.
// Backpressure: in_ready_o only in IDLE; PATTERN_FRAMER_STUFF_EN adds payload stuffing.
module pattern_framer
    import pattern_pkg::*;
#(
    parameter int                DATA_W   = 8,
    parameter int                SYNC_W   = SYNC_W_DEF,
    parameter logic [SYNC_W-1:0] SYNC_PAT = SYNC_W'(SYNC_PAT_DEF),
    parameter int                GAP_BITS = 2,
    parameter int                CNT_W    = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              bit_en_i,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              in_ready_o,
    output logic              valid_o,
    output logic              d_o,
    output logic              busy_o,
    output logic              frame_done_o,
    output logic [CNT_W-1:0]  frame_cnt_o
);

    state_t              state, state_nxt;
    logic [IDX_W-1:0]    idx, idx_nxt;
    logic [DATA_W-1:0]   data_sh, data_nxt;
    logic [SYNC_W-1:0]   sync_sh, sync_nxt;
    logic                valid_q, valid_nxt;
    logic                d_q, d_nxt;
    logic                done_q, done_nxt;
    logic [CNT_W-1:0]    cnt_q, cnt_nxt;

    logic sync_last, data_last, gap_last;
    logic stuff, emit_bit;

    assign sync_last = (idx == IDX_W'(SYNC_W - 1));
    assign data_last = (idx == IDX_W'(DATA_W - 1));
    assign gap_last  = (idx == IDX_W'(GAP_BITS - 1));

`ifdef PATTERN_FRAMER_STUFF_EN
    logic hist_clear, hist_adv;

    // History restarts when SYNC hands over to DATA
    assign hist_clear = (state == SYNC) && bit_en_i && sync_last;
    assign hist_adv   = (state == DATA) && bit_en_i;

    pattern_stuffer u_stuffer (
        .clk      (clk_i),
        .rst_n    (rst_i),
        .clear    (hist_clear),
        .advance  (hist_adv),
        .emit_bit (emit_bit),
        .stuff    (stuff)
    );
`else
    assign stuff = 1'b0;
`endif

    // A stuffed slot carries B and leaves the payload shifter untouched
    assign emit_bit = stuff ? SYM_B : data_sh[DATA_W-1];

    assign in_ready_o   = (state == IDLE);
    assign busy_o       = (state != IDLE);
    assign valid_o      = valid_q;
    assign d_o          = d_q;
    assign frame_done_o = done_q;
    assign frame_cnt_o  = cnt_q;

    // Next state and datapath; strobe-less edges only drop valid
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        data_nxt  = data_sh;
        sync_nxt  = sync_sh;
        valid_nxt = 1'b0;
        d_nxt     = d_q;
        done_nxt  = 1'b0;
        cnt_nxt   = cnt_q;
        case (state)
            IDLE: begin
                if (in_valid_i) begin
                    data_nxt  = in_data_i;
                    sync_nxt  = SYNC_PAT;
                    idx_nxt   = '0;
                    state_nxt = SYNC;
                end
            end
            SYNC: begin
                if (bit_en_i) begin
                    d_nxt     = sync_sh[SYNC_W-1];
                    valid_nxt = 1'b1;
                    sync_nxt  = sync_sh << 1;
                    if (sync_last) begin
                        idx_nxt   = '0;
                        state_nxt = DATA;
                    end else begin
                        idx_nxt = idx + IDX_W'(1);
                    end
                end
            end
            DATA: begin
                if (bit_en_i) begin
                    d_nxt     = emit_bit;
                    valid_nxt = 1'b1;
                    if (!stuff) begin
                        data_nxt = data_sh << 1;
                        if (data_last) begin
                            done_nxt  = 1'b1;
                            cnt_nxt   = cnt_q + CNT_W'(1);
                            idx_nxt   = '0;
                            state_nxt = (GAP_BITS == 0) ? IDLE : GAP;
                        end else begin
                            idx_nxt = idx + IDX_W'(1);
                        end
                    end
                end
            end
            GAP: begin
                if (bit_en_i) begin
                    if (gap_last) begin
                        idx_nxt   = '0;
                        state_nxt = IDLE;
                    end else begin
                        idx_nxt = idx + IDX_W'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath and registered serial outputs
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            idx     <= '0;
            data_sh <= '0;
            sync_sh <= '0;
            valid_q <= 1'b0;
            d_q     <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            idx     <= idx_nxt;
            data_sh <= data_nxt;
            sync_sh <= sync_nxt;
            valid_q <= valid_nxt;
            d_q     <= d_nxt;
            done_q  <= done_nxt;
            cnt_q   <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_pattern_framer.sv
// Bench for pattern_framer: slot-queue reference model plus literal frame checks.
// Latency: model expects first bit on the strobe edge after acceptance.
// Backpressure: source holds in_valid_i until in_ready_o; PATTERN_FRAMER_STUFF_EN selects stuffed expectations.
module tb_pattern_framer;

    localparam int GAP_BITS = 2;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       bit_en_i;
    logic       in_valid_i;
    logic [7:0] in_data_i;
    logic       in_ready_o, valid_o, d_o, busy_o, frame_done_o;
    logic [7:0] frame_cnt_o;

    pattern_framer dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .bit_en_i     (bit_en_i),
        .in_valid_i   (in_valid_i),
        .in_data_i    (in_data_i),
        .in_ready_o   (in_ready_o),
        .valid_o      (valid_o),
        .d_o          (d_o),
        .busy_o       (busy_o),
        .frame_done_o (frame_done_o),
        .frame_cnt_o  (frame_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each accepted word becomes a list of line slots
    typedef struct {
        bit is_bit;
        bit val;
        bit last;
    } slot_t;

    slot_t q[$];
    int    exp_cnt  = 0;
    bit    exp_d    = 0;
    bit    exp_v    = 0;
    bit    exp_done = 0;

    bit bit_log[$];
    int done_log = 0;

    function automatic void push_frame(input logic [7:0] w);
        logic [4:0] sp;
        logic [3:0] hist;
        slot_t      s;
        int         i;
        sp = 5'b01101;
        for (int k = 4; k >= 0; k--) begin
            s.is_bit = 1; s.val = sp[k]; s.last = 0;
            q.push_back(s);
        end
        hist = 4'b0000;
        i = 7;
        while (i >= 0) begin
`ifdef PATTERN_FRAMER_STUFF_EN
            if (hist == 4'b0110) begin
                s.is_bit = 1; s.val = 0; s.last = 0;
                q.push_back(s);
                hist = {hist[2:0], 1'b0};
                continue;
            end
`endif
            s.is_bit = 1; s.val = w[i]; s.last = (i == 0);
            q.push_back(s);
            hist = {hist[2:0], w[i]};
            i--;
        end
        for (int g = 0; g < GAP_BITS; g++) begin
            s.is_bit = 0; s.val = 0; s.last = 0;
            q.push_back(s);
        end
    endfunction

    // Non-overlapping sync detector over a captured bit stream
    function automatic int count_sync(input bit b[$]);
        logic [4:0] sr;
        int         filled, n;
        sr = '0; filled = 0; n = 0;
        foreach (b[k]) begin
            sr = {sr[3:0], b[k]};
            filled++;
            if (filled >= 5 && sr == 5'b01101) begin
                n++;
                filled = 0;
            end
        end
        return n;
    endfunction

    function automatic logic [31:0] pack_log();
        logic [31:0] v;
        v = '0;
        foreach (bit_log[k]) v = {v[30:0], bit_log[k]};
        return v;
    endfunction

    // Compare process: capture pre-edge inputs, advance model, check post-edge outputs
    initial begin
        bit         acc, ben, rs, rdy;
        logic [7:0] dat;
        slot_t      s;
        forever begin
            @(negedge clk_i);
            #2;
            rdy = (q.size() == 0);
            rs  = rst_i;
            ben = bit_en_i;
            acc = rst_i && in_valid_i && rdy;
            dat = in_data_i;
            @(posedge clk_i);
            #1;
            if (!rs || !rst_i) begin
                q.delete();
                exp_cnt = 0; exp_d = 0; exp_v = 0; exp_done = 0;
            end else begin
                exp_v = 0; exp_done = 0;
                if (ben && q.size() != 0) begin
                    s = q.pop_front();
                    exp_v = s.is_bit;
                    if (s.is_bit) exp_d = s.val;
                    exp_done = s.is_bit && s.last;
                    if (exp_done) exp_cnt = (exp_cnt + 1) % 256;
                end
                if (acc) push_frame(dat);
            end
            check("valid_o", 32'(valid_o), 32'(exp_v));
            check("d_o", 32'(d_o), 32'(exp_d));
            check("frame_done_o", 32'(frame_done_o), 32'(exp_done));
            check("frame_cnt_o", 32'(frame_cnt_o), 32'(exp_cnt));
            check("in_ready_o", 32'(in_ready_o), 32'(q.size() == 0));
            check("busy_o", 32'(busy_o), 32'(q.size() != 0));
            if (valid_o) bit_log.push_back(d_o);
            if (frame_done_o) done_log++;
        end
    end

    // Strobe generator: 0 = every cycle, 1 = one in three, 2 = random
    int ben_mode = 0;
    int ben_ph   = 0;
    initial begin
        bit_en_i = 1'b0;
        forever begin
            @(negedge clk_i);
            case (ben_mode)
                0: bit_en_i = 1'b1;
                1: begin
                    bit_en_i = (ben_ph == 0);
                    ben_ph   = (ben_ph + 1) % 3;
                end
                default: bit_en_i = ($urandom_range(1, 0) == 1);
            endcase
        end
    end

    task automatic send(input logic [7:0] w);
        int n;
        in_data_i  = w;
        in_valid_i = 1'b1;
        n = 0;
        forever begin
            #1;
            if (in_ready_o) break;
            @(negedge clk_i);
            n++;
            if (n > 400) begin
                check("accept_timeout", 32'(n), 32'(0));
                break;
            end
        end
        @(negedge clk_i);
        in_valid_i = 1'b0;
        in_data_i  = 8'($urandom);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        forever begin
            @(negedge clk_i);
            #1;
            if (in_ready_o) break;
            n++;
            if (n > 600) begin
                check("idle_timeout", 32'(n), 32'(0));
                break;
            end
        end
    endtask

    task automatic clear_logs();
        bit_log.delete();
        done_log = 0;
    endtask

    // Stimulus
    initial begin
        int n;
        rst_i      = 1'b0;
        in_valid_i = 1'b0;
        in_data_i  = 8'h00;
        #1;
        check("rst_valid", 32'(valid_o), 32'(0));
        check("rst_d", 32'(d_o), 32'(0));
        check("rst_done", 32'(frame_done_o), 32'(0));
        check("rst_cnt", 32'(frame_cnt_o), 32'(0));
        check("rst_busy", 32'(busy_o), 32'(0));
        check("rst_ready", 32'(in_ready_o), 32'(1));
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);

        // Continuous strobe, word A5
        ben_mode = 0;
        clear_logs();
        send(8'hA5);
        wait_idle();
        check("a5_bits", pack_log(), 32'b0110110100101);
        check("a5_len", 32'(bit_log.size()), 32'd13);
        check("a5_done", 32'(done_log), 32'd1);
        check("a5_cnt", 32'(frame_cnt_o), 32'd1);

        // Sparse strobe, word 3C
        ben_mode = 1;
        clear_logs();
        send(8'h3C);
        wait_idle();
        check("3c_bits", pack_log(), 32'b0110100111100);
        check("3c_done", 32'(done_log), 32'd1);

        // Back-to-back words with in_valid_i held high
        ben_mode = 0;
        clear_logs();
        send(8'h01);
        send(8'hFF);
        wait_idle();
        check("b2b_len", 32'(bit_log.size()), 32'd26);
        check("b2b_done", 32'(done_log), 32'd2);
        check("b2b_cnt", 32'(frame_cnt_o), 32'd4);

        // Reset during the 4th payload bit
        clear_logs();
        send(8'hA5);
        n = 0;
        while (bit_log.size() < 8 && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        check("mid_reset_reach", 32'(bit_log.size()), 32'd8);
        rst_i = 1'b0;
        #1;
        check("mid_reset_valid", 32'(valid_o), 32'(0));
        check("mid_reset_d", 32'(d_o), 32'(0));
        check("mid_reset_cnt", 32'(frame_cnt_o), 32'(0));
        check("mid_reset_ready", 32'(in_ready_o), 32'(1));
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        clear_logs();
        send(8'hA5);
        wait_idle();
        check("post_reset_bits", pack_log(), 32'b0110110100101);
        check("post_reset_cnt", 32'(frame_cnt_o), 32'd1);

        // Payload that contains the sync pattern
        clear_logs();
        send(8'h6D);
        wait_idle();
`ifdef PATTERN_FRAMER_STUFF_EN
        check("6d_bits", pack_log(), 32'b011010110011001);
        check("6d_len", 32'(bit_log.size()), 32'd15);
        check("6d_detect", 32'(count_sync(bit_log)), 32'd1);
`else
        check("6d_bits", pack_log(), 32'b0110101101101);
        check("6d_len", 32'(bit_log.size()), 32'd13);
        check("6d_detect", 32'(count_sync(bit_log)), 32'd2);
`endif

        // Randomized words, strobes and source idle gaps
        ben_mode = 2;
        clear_logs();
        for (int f = 0; f < 150; f++) begin
            repeat ($urandom_range(3, 0)) @(negedge clk_i);
            send(8'($urandom));
        end
        wait_idle();
        check("rand_done", 32'(done_log), 32'd150);

        // Counter wrap: 255 frames, then one more
        ben_mode = 0;
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        for (int f = 0; f < 255; f++) send(8'($urandom));
        wait_idle();
        check("wrap_pre", 32'(frame_cnt_o), 32'd255);
        clear_logs();
        send(8'h5A);
        wait_idle();
        check("wrap_cnt", 32'(frame_cnt_o), 32'd0);
        check("wrap_done", 32'(done_log), 32'd1);

        repeat (3) @(negedge clk_i);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global time bound
    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "timeout");
    end

endmodule
